riscv_core_mem_arbiter: RTL and testbench

- Sits directly downstream of riscv_Core. Merges the core's instruction and data memory request ports onto one shared memory port.
- Routes each in-order memory response back to the port that issued the matching request.
- Round-robin arbitration, plus an outstanding-request tag FIFO for response steering.
- Lets a single-ported test memory or cache serve the 5-stage pipeline.

---
 rtl/riscv_core_mem_arbiter_pkg.sv | 21 ++
 rtl/riscv_core_mem_arbiter_tagq.sv | 53 +++++
 rtl/riscv_core_mem_arbiter.sv | 90 +++++++++
 tb/tb_riscv_core_mem_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_core_mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
// Message widths follow the vc memory message layout: type, addr, len, data.
package riscv_core_mem_arbiter_pkg;

    typedef enum logic {
        PORT_IMEM = 1'b0,
        PORT_DMEM = 1'b1
    } port_e;

    function automatic int mem_req_msg_sz(input int addr_w, input int data_w);
        return 1 + addr_w + $clog2(data_w / 8) + data_w;
    endfunction

    function automatic int mem_resp_msg_sz(input int data_w);
        return 1 + $clog2(data_w / 8) + data_w;
    endfunction

    localparam int MEM_REQ_SZ  = mem_req_msg_sz(32, 32);
    localparam int MEM_RESP_SZ = mem_resp_msg_sz(32);

endpackage

// File: rtl/riscv_core_mem_arbiter_tagq.sv
// One-bit-wide tag FIFO recording which port issued each in-flight request.
// Enqueue is ignored while full and dequeue is ignored while empty.
module riscv_core_mem_arbiter_tagq #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enq,
    input  logic                     enq_data,
    input  logic                     deq,
    output logic                     deq_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_enq;
    logic             do_deq;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_enq   = enq & ~full;
    assign do_deq   = deq & ~empty;
    assign deq_data = mem[rd_ptr];

    // DEPTH is a power of two, so pointer overflow is the wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_enq) begin
                mem[wr_ptr] <= enq_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_deq)
                rd_ptr <= rd_ptr + AW'(1);
            case ({do_enq, do_deq})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/riscv_core_mem_arbiter.sv
// Round-robin merge of the core's imem/dmem request ports onto one memory port,
// with in-order responses steered back by a tag FIFO.
module riscv_core_mem_arbiter
    import riscv_core_mem_arbiter_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int REQ_SZ          = MEM_REQ_SZ,
    parameter int RESP_SZ         = MEM_RESP_SZ
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [REQ_SZ-1:0]                  imemreq_msg,
    input  logic                               imemreq_val,
    output logic                               imemreq_rdy,
    output logic [RESP_SZ-1:0]                 imemresp_msg,
    output logic                               imemresp_val,
    input  logic [REQ_SZ-1:0]                  dmemreq_msg,
    input  logic                               dmemreq_val,
    output logic                               dmemreq_rdy,
    output logic [RESP_SZ-1:0]                 dmemresp_msg,
    output logic                               dmemresp_val,
    output logic [REQ_SZ-1:0]                  memreq_msg,
    output logic                               memreq_val,
    input  logic                               memreq_rdy,
    input  logic [RESP_SZ-1:0]                 memresp_msg,
    input  logic                               memresp_val,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_cnt,
    output logic                               resp_err
);

    port_e last_grant;
    port_e grant;
    logic  full;
    logic  empty;
    logic  head;
    logic  push;
    logic  pop;
    logic  port_rdy;

    // Grant depends only on the request valids and history, never on rdy.
    always_comb begin
        grant = PORT_IMEM;
        if (imemreq_val && dmemreq_val)
            grant = (last_grant == PORT_IMEM) ? PORT_DMEM : PORT_IMEM;
        else if (dmemreq_val)
            grant = PORT_DMEM;
    end

    assign memreq_msg  = (grant == PORT_DMEM) ? dmemreq_msg : imemreq_msg;
    assign memreq_val  = reset & (imemreq_val | dmemreq_val) & ~full;
    assign port_rdy    = reset & memreq_rdy & ~full;
    assign imemreq_rdy = port_rdy & (grant == PORT_IMEM);
    assign dmemreq_rdy = port_rdy & (grant == PORT_DMEM);

    assign push = memreq_val & memreq_rdy;
    assign pop  = reset & memresp_val & ~empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= PORT_DMEM;
            resp_err   <= 1'b0;
        end else begin
            if (push)
                last_grant <= grant;
            if (memresp_val && empty)
                resp_err <= 1'b1;
        end
    end

    riscv_core_mem_arbiter_tagq #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_tagq (
        .clk      (clk),
        .rst_n    (reset),
        .enq      (push),
        .enq_data (grant),
        .deq      (pop),
        .deq_data (head),
        .full     (full),
        .empty    (empty),
        .count    (outstanding_cnt)
    );

    // Responses are broadcast; only the valid is steered by the head tag.
    assign imemresp_msg = memresp_msg;
    assign dmemresp_msg = memresp_msg;
    assign imemresp_val = pop & (head == PORT_IMEM);
    assign dmemresp_val = pop & (head == PORT_DMEM);

endmodule

// File: tb/tb_riscv_core_mem_arbiter.sv
// Directed table-driven bench for riscv_core_mem_arbiter, plus hand sequences
// for sticky error persistence and asynchronous mid-operation reset.
module tb_riscv_core_mem_arbiter;
    import riscv_core_mem_arbiter_pkg::*;

    localparam int REQ_SZ  = 67;
    localparam int RESP_SZ = 35;

    logic               clk = 1'b0;
    logic               reset;
    logic [REQ_SZ-1:0]  imemreq_msg, dmemreq_msg, memreq_msg;
    logic               imemreq_val, imemreq_rdy, dmemreq_val, dmemreq_rdy;
    logic [RESP_SZ-1:0] imemresp_msg, dmemresp_msg, memresp_msg;
    logic               imemresp_val, dmemresp_val;
    logic               memreq_val, memreq_rdy, memresp_val;
    logic [2:0]         outstanding_cnt;
    logic               resp_err;

    riscv_core_mem_arbiter dut (
        .clk(clk), .reset(reset),
        .imemreq_msg(imemreq_msg), .imemreq_val(imemreq_val), .imemreq_rdy(imemreq_rdy),
        .imemresp_msg(imemresp_msg), .imemresp_val(imemresp_val),
        .dmemreq_msg(dmemreq_msg), .dmemreq_val(dmemreq_val), .dmemreq_rdy(dmemreq_rdy),
        .dmemresp_msg(dmemresp_msg), .dmemresp_val(dmemresp_val),
        .memreq_msg(memreq_msg), .memreq_val(memreq_val), .memreq_rdy(memreq_rdy),
        .memresp_msg(memresp_msg), .memresp_val(memresp_val),
        .outstanding_cnt(outstanding_cnt), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    // type, addr, len, data
    localparam logic [REQ_SZ-1:0] IMSG = {1'b0, 32'h0000_0200, 2'd0, 32'h0000_0000};
    localparam logic [REQ_SZ-1:0] DMSG = {1'b1, 32'h0000_1000, 2'd0, 32'hDEAD_BEEF};

    typedef struct {
        logic        iv, dv, rdy, rv;
        logic [31:0] rdata;
        logic        mval, gnt, irdy, drdy, ival, dval;
        logic [2:0]  cnt;
        logic        err;
    } vec_t;

    vec_t vec[0:32];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(logic iv, logic dv, logic rdy, logic rv, logic [31:0] rdata,
                                logic mval, logic gnt, logic irdy, logic drdy,
                                logic ival, logic dval, logic [2:0] cnt, logic err);
        vec_t v;
        v.iv = iv; v.dv = dv; v.rdy = rdy; v.rv = rv; v.rdata = rdata;
        v.mval = mval; v.gnt = gnt; v.irdy = irdy; v.drdy = drdy;
        v.ival = ival; v.dval = dval; v.cnt = cnt; v.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic dv, input logic rdy,
                         input logic rv, input logic [31:0] rdata);
        imemreq_val = iv;
        dmemreq_val = dv;
        memreq_rdy  = rdy;
        memresp_val = rv;
        memresp_msg = {1'b0, 2'd0, rdata};
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, ".memreq_val"},   memreq_val, 1'b0);
        chk({tag, ".imemreq_rdy"},  imemreq_rdy, 1'b0);
        chk({tag, ".dmemreq_rdy"},  dmemreq_rdy, 1'b0);
        chk({tag, ".imemresp_val"}, imemresp_val, 1'b0);
        chk({tag, ".dmemresp_val"}, dmemresp_val, 1'b0);
        chk({tag, ".cnt"},          outstanding_cnt, 3'd0);
        chk({tag, ".resp_err"},     resp_err, 1'b0);
    endtask

    initial begin
        // single imem read, then a dmem read to set last_grant=DMEM
        vec[0]  = mk(1,0,1,0,32'h0,         1,0,1,0,0,0,3'd0,0);
        vec[1]  = mk(0,0,1,1,32'h0000_0013, 0,0,1,0,1,0,3'd1,0);
        vec[2]  = mk(0,1,1,0,32'h0,         1,1,0,1,0,0,3'd0,0);
        vec[3]  = mk(0,0,1,1,32'h0000_00AA, 0,0,1,0,0,1,3'd1,0);
        // four conflicting handshakes alternate I,D,I,D
        vec[4]  = mk(1,1,1,0,32'h0,         1,0,1,0,0,0,3'd0,0);
        vec[5]  = mk(1,1,1,0,32'h0,         1,1,0,1,0,0,3'd1,0);
        vec[6]  = mk(1,1,1,0,32'h0,         1,0,1,0,0,0,3'd2,0);
        vec[7]  = mk(1,1,1,0,32'h0,         1,1,0,1,0,0,3'd3,0);
        vec[8]  = mk(1,1,1,0,32'h0,         0,0,0,0,0,0,3'd4,0);
        // in-order responses D0..D3 steer imem, dmem, imem, dmem
        vec[9]  = mk(0,0,1,1,32'hD000_0000, 0,0,0,0,1,0,3'd4,0);
        vec[10] = mk(0,0,1,1,32'hD000_0001, 0,0,1,0,0,1,3'd3,0);
        vec[11] = mk(0,0,1,1,32'hD000_0002, 0,0,1,0,1,0,3'd2,0);
        vec[12] = mk(0,0,1,1,32'hD000_0003, 0,0,1,0,0,1,3'd1,0);
        // memory stalls: grant holds at IMEM, nothing pushed
        vec[13] = mk(1,1,0,0,32'h0,         1,0,0,0,0,0,3'd0,0);
        vec[14] = mk(1,1,0,0,32'h0,         1,0,0,0,0,0,3'd0,0);
        vec[15] = mk(1,1,0,0,32'h0,         1,0,0,0,0,0,3'd0,0);
        vec[16] = mk(1,1,1,0,32'h0,         1,0,1,0,0,0,3'd0,0);
        vec[17] = mk(0,0,1,1,32'h0000_0055, 0,0,1,0,1,0,3'd1,0);
        // fill with dmem requests, then pop-while-full does not push
        vec[18] = mk(0,1,1,0,32'h0,         1,1,0,1,0,0,3'd0,0);
        vec[19] = mk(0,1,1,0,32'h0,         1,1,0,1,0,0,3'd1,0);
        vec[20] = mk(0,1,1,0,32'h0,         1,1,0,1,0,0,3'd2,0);
        vec[21] = mk(0,1,1,0,32'h0,         1,1,0,1,0,0,3'd3,0);
        vec[22] = mk(0,1,1,0,32'h0,         0,1,0,0,0,0,3'd4,0);
        vec[23] = mk(0,1,1,1,32'hE000_0000, 0,1,0,0,0,1,3'd4,0);
        vec[24] = mk(0,1,1,0,32'h0,         1,1,0,1,0,0,3'd3,0);
        vec[25] = mk(0,0,1,0,32'h0,         0,0,0,0,0,0,3'd4,0);
        vec[26] = mk(0,0,1,1,32'hE000_0001, 0,0,0,0,0,1,3'd4,0);
        vec[27] = mk(0,0,1,1,32'hE000_0002, 0,0,1,0,0,1,3'd3,0);
        vec[28] = mk(0,0,1,1,32'hE000_0003, 0,0,1,0,0,1,3'd2,0);
        vec[29] = mk(0,0,1,1,32'hE000_0004, 0,0,1,0,0,1,3'd1,0);
        vec[30] = mk(0,0,1,0,32'h0,         0,0,1,0,0,0,3'd0,0);
        // response with nothing outstanding
        vec[31] = mk(0,0,1,1,32'h0000_0BAD, 0,0,1,0,0,0,3'd0,0);
        vec[32] = mk(0,0,1,0,32'h0,         0,0,1,0,0,0,3'd0,1);

        imemreq_msg = IMSG;
        dmemreq_msg = DMSG;

        // outputs are forced idle while reset is held, even with live inputs
        reset = 1'b0;
        drive(1, 1, 1, 1, 32'h1234);
        #2;
        chk_idle_outputs("in_reset");
        @(negedge clk);
        drive(0, 0, 0, 0, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 33; i++) begin
            string t;
            @(negedge clk);
            drive(vec[i].iv, vec[i].dv, vec[i].rdy, vec[i].rv, vec[i].rdata);
            #1;
            t = $sformatf("v%0d", i);
            chk({t, ".memreq_val"},   memreq_val,   vec[i].mval);
            chk({t, ".memreq_msg"},   memreq_msg,   vec[i].gnt ? DMSG : IMSG);
            chk({t, ".imemreq_rdy"},  imemreq_rdy,  vec[i].irdy);
            chk({t, ".dmemreq_rdy"},  dmemreq_rdy,  vec[i].drdy);
            chk({t, ".imemresp_val"}, imemresp_val, vec[i].ival);
            chk({t, ".dmemresp_val"}, dmemresp_val, vec[i].dval);
            chk({t, ".cnt"},          outstanding_cnt, vec[i].cnt);
            chk({t, ".resp_err"},     resp_err,     vec[i].err);
            if (vec[i].ival)
                chk({t, ".imemresp_msg"}, imemresp_msg, {3'b000, vec[i].rdata});
            if (vec[i].dval)
                chk({t, ".dmemresp_msg"}, dmemresp_msg, {3'b000, vec[i].rdata});
        end

        // sticky error persists across idle cycles
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(0, 0, 1, 0, 32'h0);
            #1;
            chk($sformatf("err_hold%0d", i), resp_err, 1'b1);
        end

        // two requests in flight, then asynchronous reset mid-cycle
        @(negedge clk);
        drive(1, 0, 1, 0, 32'h0);
        @(negedge clk);
        drive(0, 1, 1, 0, 32'h0);
        @(negedge clk);
        drive(1, 1, 1, 1, 32'h0);
        #1;
        chk("pre_rst.cnt", outstanding_cnt, 3'd2);
        chk("pre_rst.err", resp_err, 1'b1);
        reset = 1'b0;
        #1;
        chk_idle_outputs("async_rst");
        @(negedge clk);
        drive(1, 1, 1, 0, 32'h0);
        reset = 1'b1;
        #1;
        chk("post_rst.msg",  memreq_msg,  IMSG);
        chk("post_rst.irdy", imemreq_rdy, 1'b1);
        chk("post_rst.drdy", dmemreq_rdy, 1'b0);
        chk("post_rst.cnt",  outstanding_cnt, 3'd0);
        @(negedge clk);
        #1;
        chk("post_rst2.msg", memreq_msg, DMSG);
        chk("post_rst2.cnt", outstanding_cnt, 3'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: sim time exceeded 100000");
        $fatal(1, "timeout");
    end

endmodule
